// File: rtl/uart_rx_ctrl.sv
// ---------------------------------------------------------------------------
// uart_rx_ctrl -- 8N1 UART receive controller (8E1 when UART_RX_PARITY_EN is
// defined).
//
// The rx line is synchronised into rx_s. After a start bit is confirmed at its
// midpoint, each following bit is sampled one bit period later, which is again
// at mid-bit. Every data bit is presented as a one-cycle shift_en/shift_bit
// strobe for an external LSB-first shift register. A copy is also collected
// internally so a complete byte can be published on data.
//
// Optional feature macro: UART_RX_PARITY_EN
//   Defined   : a PARITY state follows DATA; even parity over data+parity.
//   Undefined : DATA goes straight to STOP (10-bit frame).
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   rx         in   asynchronous serial line, idle high
//   shift_en   out  one-cycle strobe per received data bit
//   shift_bit  out  sampled bit value, valid with shift_en
//   data[7:0]  out  last good received byte
//   data_valid out  one-cycle pulse when data updates
//   frame_err  out  one-cycle pulse on bad stop (or parity) bit
//   busy       out  high whenever the receiver is not idle
// ---------------------------------------------------------------------------
module uart_rx_ctrl #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic       shift_en,
  output logic       shift_bit,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] STOP   = 3'd3;
  localparam logic [2:0] BREAK  = 3'd4;
  localparam logic [2:0] PARITY = 3'd5;

  logic             rx_meta_r;
  logic             rx_s;
  logic [2:0]       state_r,   state_nxt;
  logic [CNT_W-1:0] cnt_r,     cnt_nxt;
  logic [CNT_W-1:0] cnt_inc_s;
  logic [2:0]       idx_r,     idx_nxt;
  logic [7:0]       sh_r,      sh_nxt;
  logic [7:0]       data_nxt;
  logic             shift_en_nxt, shift_bit_nxt, data_valid_nxt, frame_err_nxt;

`ifdef UART_RX_PARITY_EN
  logic             par_r, par_nxt;

  // Even parity holds when data plus the parity bit contain an even number of ones.
  function automatic logic even_parity_ok(input logic [7:0] d, input logic p);
    return ~(^{d, p});
  endfunction
`endif

  assign cnt_inc_s = cnt_r + CNT_W'(1);

  // Two-flop synchroniser for the asynchronous rx line (resets to idle level).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_r <= 1'b1;
      rx_s      <= 1'b1;
    end else begin
      rx_meta_r <= rx;
      rx_s      <= rx_meta_r;
    end
  end

  // Next-state and next-output decode for the receive sequencer.
  always_comb begin
    state_nxt      = state_r;
    cnt_nxt        = cnt_r;
    idx_nxt        = idx_r;
    sh_nxt         = sh_r;
    data_nxt       = data;
    shift_en_nxt   = 1'b0;
    shift_bit_nxt  = 1'b0;
    data_valid_nxt = 1'b0;
    frame_err_nxt  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_nxt        = par_r;
`endif
    case (state_r)
      IDLE: begin
        cnt_nxt = {CNT_W{1'b0}};
        if (!rx_s) begin
          state_nxt = START;
        end else begin
          state_nxt = IDLE;
        end
      end
      START: begin
        // Re-check the line at mid start bit; a high level means a glitch.
        if (cnt_r == HALF_M1) begin
          cnt_nxt = {CNT_W{1'b0}};
          if (rx_s) begin
            state_nxt = IDLE;
          end else begin
            state_nxt = DATA;
          end
        end else begin
          cnt_nxt = cnt_inc_s;
        end
      end
      DATA: begin
        if (cnt_r == FULL_M1) begin
          cnt_nxt       = {CNT_W{1'b0}};
          shift_en_nxt  = 1'b1;
          shift_bit_nxt = rx_s;
          sh_nxt        = {rx_s, sh_r[7:1]};
          idx_nxt       = idx_r + 3'd1;   // wraps to 0 after bit 7
          if (idx_r == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_nxt = PARITY;
`else
            state_nxt = STOP;
`endif
          end else begin
            state_nxt = DATA;
          end
        end else begin
          cnt_nxt = cnt_inc_s;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_r == FULL_M1) begin
          cnt_nxt   = {CNT_W{1'b0}};
          par_nxt   = rx_s;
          state_nxt = STOP;
        end else begin
          cnt_nxt = cnt_inc_s;
        end
      end
`endif
      STOP: begin
        if (cnt_r == FULL_M1) begin
          cnt_nxt = {CNT_W{1'b0}};
          if (rx_s) begin
            state_nxt = IDLE;
`ifdef UART_RX_PARITY_EN
            // A parity failure is only reported once the stop bit is seen.
            if (even_parity_ok(sh_r, par_r)) begin
              data_nxt       = sh_r;
              data_valid_nxt = 1'b1;
            end else begin
              frame_err_nxt  = 1'b1;
            end
`else
            data_nxt       = sh_r;
            data_valid_nxt = 1'b1;
`endif
          end else begin
            frame_err_nxt = 1'b1;
            state_nxt     = BREAK;
          end
        end else begin
          cnt_nxt = cnt_inc_s;
        end
      end
      BREAK: begin
        cnt_nxt = {CNT_W{1'b0}};
        if (rx_s) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = BREAK;
        end
      end
      default: begin
        cnt_nxt   = {CNT_W{1'b0}};
        state_nxt = IDLE;
      end
    endcase
  end

  // State, datapath and registered output update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      cnt_r      <= {CNT_W{1'b0}};
      idx_r      <= 3'd0;
      sh_r       <= 8'h00;
      data       <= 8'h00;
      shift_en   <= 1'b0;
      shift_bit  <= 1'b0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_r      <= 1'b0;
`endif
    end else begin
      state_r    <= state_nxt;
      cnt_r      <= cnt_nxt;
      idx_r      <= idx_nxt;
      sh_r       <= sh_nxt;
      data       <= data_nxt;
      shift_en   <= shift_en_nxt;
      shift_bit  <= shift_bit_nxt;
      data_valid <= data_valid_nxt;
      frame_err  <= frame_err_nxt;
      // busy tracks the state being entered so it lines up with state_r.
      busy       <= (state_nxt != IDLE);
`ifdef UART_RX_PARITY_EN
      par_r      <= par_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_ctrl -- scoreboard bench for uart_rx_ctrl (CLKS_PER_BIT = 16).
// The stimulus side serialises frames on rx and pushes the expected data-bit
// strobes and the expected frame outcome into queues. A monitor pops and
// compares whenever the DUT strobes shift_en, data_valid or frame_err.
// ---------------------------------------------------------------------------
module tb_uart_rx_ctrl;

  localparam int CPB = 16;

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic       shift_en;
  logic       shift_bit;
  logic [7:0] data;
  logic       data_valid;
  logic       frame_err;
  logic       busy;

  uart_rx_ctrl #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .shift_en   (shift_en),
    .shift_bit  (shift_bit),
    .data       (data),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       err;
    logic [7:0] d;
  } outc_t;

  bit         exp_bits[$];
  outc_t      exp_out[$];
  logic [7:0] last_good;
  int         vec_cnt;
  int         err_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input logic v);
    rx = v;
    wait_cycles(CPB);
  endtask

  // Reference model: data bits arrive LSB first; a frame is good only when
  // the stop bit is 1 (and, with parity enabled, data+parity has even weight).
  task automatic push_expect(input logic [7:0] b, input logic stop, input logic par);
    outc_t o;
    for (int k = 0; k < 8; k++) exp_bits.push_back(b[k]);
    o.err = ~stop;
`ifdef UART_RX_PARITY_EN
    if ((^b) != par) o.err = 1'b1;
`else
    if (par === 1'bx) o.err = 1'b1;
`endif
    o.d = b;
    exp_out.push_back(o);
  endtask

  // Sends start, 8 data bits (parity) and stop; rx is left at the stop level.
  task automatic drive_frame(input logic [7:0] b, input logic stop, input logic par);
    push_expect(b, stop, par);
    drive_bit(1'b0);
    for (int k = 0; k < 8; k++) drive_bit(b[k]);
`ifdef UART_RX_PARITY_EN
    drive_bit(par);
`endif
    drive_bit(stop);
  endtask

  task automatic check_drained(input string name);
    check({name, "_bits_left"}, 32'(exp_bits.size()), 32'd0);
    check({name, "_results_left"}, 32'(exp_out.size()), 32'd0);
  endtask

  // Monitor: compare every DUT strobe against the head of the scoreboard.
  always @(negedge clk) begin
    bit    b;
    outc_t o;
    if (rst_n) begin
      if (shift_en) begin
        check("shift_expected", 32'(exp_bits.size() != 0), 32'd1);
        if (exp_bits.size() != 0) begin
          b = exp_bits.pop_front();
          check("shift_bit", 32'(shift_bit), 32'(b));
        end
      end
      if (data_valid || frame_err) begin
        check("valid_err_exclusive", 32'(data_valid & frame_err), 32'd0);
        check("result_expected", 32'(exp_out.size() != 0), 32'd1);
        if (exp_out.size() != 0) begin
          o = exp_out.pop_front();
          check("frame_err_kind", 32'(frame_err), 32'(o.err));
          if (!o.err) begin
            check("data_value", 32'(data), 32'(o.d));
            last_good = o.d;
          end else begin
            check("data_held", 32'(data), 32'(last_good));
          end
        end
      end
    end
  end

  initial begin
    logic [7:0] b;
    logic       stop;
    logic       par;
    vec_cnt   = 0;
    err_cnt   = 0;
    last_good = 8'h00;
    rx        = 1'b1;
    rst_n     = 1'b0;
    wait_cycles(3);

    // Reset state.
    check("rst_shift_en",   32'(shift_en),   32'd0);
    check("rst_shift_bit",  32'(shift_bit),  32'd0);
    check("rst_data",       32'(data),       32'd0);
    check("rst_data_valid", 32'(data_valid), 32'd0);
    check("rst_frame_err",  32'(frame_err),  32'd0);
    check("rst_busy",       32'(busy),       32'd0);
    rst_n = 1'b1;
    wait_cycles(5);

    // Single good frame 0xA5.
    drive_frame(8'hA5, 1'b1, ^(8'hA5));
    wait_cycles(30);
    check("a5_busy_after", 32'(busy), 32'd0);
    check("a5_data", 32'(data), 32'h0000_00A5);
    check_drained("a5");

    // Back-to-back 0x00, 0xFF with no idle gap.
    drive_frame(8'h00, 1'b1, 1'b0);
    drive_frame(8'hFF, 1'b1, 1'b0);
    wait_cycles(30);
    check("b2b_data", 32'(data), 32'h0000_00FF);
    check_drained("b2b");

    // Short low glitch must be rejected as a start bit.
    rx = 1'b0;
    wait_cycles(6);
    rx = 1'b1;
    wait_cycles(30);
    check("glitch_busy", 32'(busy), 32'd0);
    check_drained("glitch");

    // Bad stop bit followed by a held-low line (break).
    drive_frame(8'h3C, 1'b0, ^(8'h3C));
    wait_cycles(20);
    check("break_busy_mid", 32'(busy), 32'd1);
    wait_cycles(20);
    check("break_busy_end", 32'(busy), 32'd1);
    rx = 1'b1;
    wait_cycles(10);
    check("break_busy_after", 32'(busy), 32'd0);
    check("break_data_held", 32'(data), 32'h0000_00FF);
    check_drained("break");

    // Reset during data bit 4: only bits 0..3 get strobed before the abort.
    b = 8'h96;
    for (int k = 0; k < 4; k++) exp_bits.push_back(b[k]);
    drive_bit(1'b0);
    for (int k = 0; k < 4; k++) drive_bit(b[k]);
    rx = b[4];
    wait_cycles(4);
    rst_n = 1'b0;
    #1;
    check("midrst_shift_en",   32'(shift_en),   32'd0);
    check("midrst_data",       32'(data),       32'd0);
    check("midrst_data_valid", 32'(data_valid), 32'd0);
    check("midrst_frame_err",  32'(frame_err),  32'd0);
    check("midrst_busy",       32'(busy),       32'd0);
    rx        = 1'b1;
    last_good = 8'h00;
    wait_cycles(5);
    rst_n = 1'b1;
    wait_cycles(5);
    drive_frame(8'h81, 1'b1, ^(8'h81));
    wait_cycles(30);
    check("post_rst_data", 32'(data), 32'h0000_0081);
    check_drained("midrst");

`ifdef UART_RX_PARITY_EN
    // Wrong parity then correct parity for 0x07.
    drive_frame(8'h07, 1'b1, 1'b0);
    wait_cycles(20);
    drive_frame(8'h07, 1'b1, 1'b1);
    wait_cycles(30);
    check("parity_data", 32'(data), 32'h0000_0007);
    check_drained("parity");
`endif

    // Randomised traffic: good frames, bad stops/parity, glitches, gaps.
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        rx = 1'b0;
        wait_cycles($urandom_range(1, 6));
        rx = 1'b1;
        wait_cycles(10);
      end else begin
        b    = 8'($urandom);
        stop = ($urandom_range(0, 5) != 0);
`ifdef UART_RX_PARITY_EN
        par  = ($urandom_range(0, 3) == 0) ? ~(^b) : (^b);
`else
        par  = 1'b0;
`endif
        drive_frame(b, stop, par);
        if (!stop) begin
          wait_cycles($urandom_range(0, 30));
          rx = 1'b1;
          wait_cycles($urandom_range(2, 10));
        end else begin
          wait_cycles($urandom_range(0, 8));
        end
      end
    end
    rx = 1'b1;
    wait_cycles(60);
    check("final_busy", 32'(busy), 32'd0);
    check_drained("random");

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, clk cycles per UART bit (50 MHz / 115200); legal range 4..65535.
REQ-002 SHALL have port clk  input  1  single system clock, all logic on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port rx  input  1  asynchronous serial line, idle high.
REQ-005 SHALL have port shift_en  output  1  one-cycle strobe per received data bit, for the downstream LSB-first shift register.
REQ-006 SHALL have port shift_bit  output  1  sampled bit value, valid while shift_en is high.
REQ-007 SHALL have port data  output  8  last good received byte.
REQ-008 SHALL have port data_valid  output  1  one-cycle pulse when data updates.
REQ-009 SHALL have port frame_err  output  1  one-cycle pulse on bad stop bit (or on bad parity when enabled).
REQ-010 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-011 SHALL pass rx through a 2-flop synchronizer (rx_s), reset value 1; all decisions use rx_s.
REQ-012 SHALL implement states IDLE, START, DATA, STOP and BREAK, plus PARITY when enabled.
REQ-013 IDLE: on rx_s==0, clear the baud counter and enter START.
REQ-014 START: at baud count CLKS_PER_BIT/2-1 (integer division), sample rx_s; if 1, treat as a glitch and return to IDLE with no output pulse; if 0, clear the counter and enter DATA.
REQ-015 DATA: at baud count CLKS_PER_BIT-1, sample rx_s, pulse shift_en with shift_bit=rx_s, shift an internal register as {rx_s, sh[7:1]}, clear the counter and increment a 3-bit bit index.
REQ-016 After bit index 7 is sampled, SHALL enter STOP (or PARITY when enabled); the bit index wraps to 0.
REQ-017 STOP: at baud count CLKS_PER_BIT-1, sample rx_s; if 1, load data<=sh, pulse data_valid and go to IDLE; if 0, pulse frame_err, leave data unchanged and go to BREAK.
REQ-018 BREAK: stay until rx_s==1, then go to IDLE; no shift_en, data_valid or frame_err pulses while in BREAK.
REQ-019 data_valid and frame_err SHALL be registered and assert on the edge after the deciding sample; they are never high together.
REQ-020 Exactly 8 shift_en pulses per accepted start bit; none for a rejected start.
REQ-021 A start bit beginning in the cycle after the return to IDLE SHALL be accepted, so back-to-back frames are supported.
REQ-022 The baud counter width SHALL be $clog2(CLKS_PER_BIT) and the counter SHALL never exceed CLKS_PER_BIT-1.

Reset
REQ-023 rst_n low SHALL asynchronously force: state IDLE, counters 0, sh 0, data 8'h00, shift_en/shift_bit/data_valid/frame_err/busy 0, synchronizer flops 1.
REQ-024 Reset mid-frame SHALL abort the frame with no pulses; after release, a frame is received only after a fresh start-bit falling edge.

Configuration
REQ-025 Macro UART_RX_PARITY_EN SHALL control the parity check.
- Defined: PARITY state after DATA; sample at CLKS_PER_BIT-1; even parity over 8 data bits plus parity bit.
- Parity mismatch: pulse frame_err after the stop bit (data not updated); go to IDLE if stop=1, BREAK if stop=0.
- Not defined: DATA goes directly to STOP; frame is 10 bits.

Verification (CLKS_PER_BIT=16, macro undefined unless stated)
REQ-026 Send 8'hA5 with stop=1 -> 8 shift_en pulses, shift_bit sequence 1,0,1,0,0,1,0,1; data=8'hA5; one data_valid pulse; busy low afterwards.
REQ-027 Send 0x00 then 0xFF back-to-back, no idle gap -> two data_valid pulses; data 8'h00 then 8'hFF.
REQ-028 6-cycle low glitch on rx -> returns to IDLE, zero shift_en pulses, no data_valid.
REQ-029 Send 8'h3C with stop=0, then hold rx low 40 cycles -> one frame_err pulse, data unchanged, busy held high until rx returns high.
REQ-030 Assert rst_n low during bit 4 of a frame -> all outputs 0 immediately; the next full frame 8'h81 is received correctly.
REQ-031 With UART_RX_PARITY_EN defined, send 8'h07 with parity 0 -> frame_err pulse, no data_valid; resend with parity 1 -> data=8'h07.
